// File: rtl/mm2s_cmd_sched_pkg.sv
// Shared types and constants for the two-channel MM2S command scheduler.
package mm2s_sched_pkg;
  localparam int BTT_W = 23;
  localparam int TAG_W = 4;
  localparam int CMD_W = 72;

  // DataMover command word field offsets (DSA, DRR and the top nibble stay zero)
  localparam int CMD_BTT_LSB   = 0;
  localparam int CMD_INCR_BIT  = 23;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_TAG_LSB   = 64;

  // Status byte bit indices
  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} chan_state_e;

  typedef struct packed {
    logic [3:0]       rsvd;
    logic [TAG_W-1:0] tag;
    logic [31:0]      saddr;
    logic             drr;
    logic             eof;
    logic [5:0]       dsa;
    logic             incr;
    logic [BTT_W-1:0] btt;
  } mm2s_cmd_t;

  function automatic mm2s_cmd_t cmd_word(input logic [BTT_W-1:0] btt, input logic eof,
                                         input logic [31:0] saddr, input logic [TAG_W-1:0] tag);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_BTT_LSB +: BTT_W]   = btt;
    w[CMD_INCR_BIT]           = 1'b1;
    w[CMD_EOF_BIT]            = eof;
    w[CMD_SADDR_LSB +: 32]    = saddr;
    w[CMD_TAG_LSB +: TAG_W]   = tag;
    return mm2s_cmd_t'(w);
  endfunction

  function automatic logic sts_is_err(input logic [7:0] sts);
    return !sts[STS_OKAY] || sts[STS_SLVERR] || sts[STS_DECERR] || sts[STS_INTERR];
  endfunction
endpackage

// File: rtl/mm2s_cmd_sched_if.sv
// DataMover MM2S command/status stream bundle; master = scheduler side.
interface mm2s_cmd_sched_if import mm2s_sched_pkg::*;;
  logic             m_axis_cmd_tvalid;
  logic             m_axis_cmd_tready;
  logic [CMD_W-1:0] m_axis_cmd_tdata;
  logic             s_axis_sts_tvalid;
  logic             s_axis_sts_tready;
  logic [7:0]       s_axis_sts_tdata;

  modport master (output m_axis_cmd_tvalid, m_axis_cmd_tdata, s_axis_sts_tready,
                  input  m_axis_cmd_tready, s_axis_sts_tvalid, s_axis_sts_tdata);
  modport slave  (input  m_axis_cmd_tvalid, m_axis_cmd_tdata, s_axis_sts_tready,
                  output m_axis_cmd_tready, s_axis_sts_tvalid, s_axis_sts_tdata);
endinterface

// File: rtl/mm2s_chan_seq.sv
// One playback channel: state, chunk address/remaining, seq tags, EOF tracking, pass count.
module mm2s_chan_seq import mm2s_sched_pkg::*; #(
  parameter int PKT_BYTES = 4096,
  parameter bit CH_ID     = 1'b0
) (
  input  logic        axilite_clk,
  input  logic        axilite_rstb,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_in,
  input  logic [31:0] base_in,
  input  logic [31:0] size_in,
  input  logic        gnt,      // this channel's chunk is loaded into the command register
  input  logic        pend,     // command register holds a command of this channel
  input  logic        cmd_hs,
  input  logic        sts_hs,
  input  logic        sts_err,
  input  logic [2:0]  sts_seq,
  input  logic        abort,
  output logic        req,
  output mm2s_cmd_t   cmd,
  output logic        busy,
  output logic        err,
  output logic [7:0]  passes
);
  chan_state_e state, state_nxt;
  logic [31:0] base_q, size_q, addr, rem, btt;
  logic        loop_q, last, start_ok;
  logic [2:0]  seq;
  logic [7:0]  eof_flag;
  logic [3:0]  inflight;

  assign start_ok = start && !stop && (state == IDLE) && (size_in[31:5] != '0);
  assign btt      = (rem > 32'(PKT_BYTES)) ? 32'(PKT_BYTES) : rem;
  assign last     = (rem <= 32'(PKT_BYTES));
  assign cmd      = cmd_word(btt[BTT_W-1:0], last, addr, {CH_ID, seq});

  // state register
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb) state <= IDLE;
    else               state <= state_nxt;

  // next state; watchdog abort overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (stop || sts_err || (gnt && last && !loop_q)) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && !pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // outputs; a same-cycle stop or error suppresses the request
  always_comb begin
    busy = (state != IDLE);
    req  = (state == RUN) && (rem != '0) && !stop && !sts_err;
  end

  // region latch and chunk walk; looped passes reload from the latched region
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb) begin
      base_q <= '0; size_q <= '0; loop_q <= 1'b0; addr <= '0; rem <= '0;
      seq <= '0; eof_flag <= '0;
    end else if (start_ok) begin
      base_q <= base_in;
      size_q <= size_in & 32'hFFFF_FFE0;
      loop_q <= loop_in;
      addr   <= base_in;
      rem    <= size_in & 32'hFFFF_FFE0;
    end else if (gnt) begin
      eof_flag[seq] <= last;
      seq           <= seq + 3'd1;
      if (last && loop_q) begin
        addr <= base_q;
        rem  <= size_q;
      end else begin
        addr <= addr + btt;
        rem  <= rem - btt;
      end
    end

  // in-flight count, sticky error and completed-pass counter
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb) begin
      inflight <= '0; err <= 1'b0; passes <= '0;
    end else begin
      if (abort)                           inflight <= '0;
      else if (cmd_hs && !sts_hs)          inflight <= inflight + 4'd1;
      else if (!cmd_hs && sts_hs && inflight != '0) inflight <= inflight - 4'd1;
      if (start_ok)     err <= 1'b0;
      else if (sts_err) err <= 1'b1;
      if (sts_hs && eof_flag[sts_seq]) passes <= passes + 8'd1;
    end
endmodule

// File: rtl/mm2s_cmd_sched.sv
// Two-channel DataMover MM2S command scheduler: round-robin chunk issue, outstanding cap,
// status error routing. Optional status watchdog enabled by MM2S_SCHED_WDOG_EN.
module mm2s_cmd_sched import mm2s_sched_pkg::*; #(
  parameter int PKT_BYTES   = 4096,
  parameter int MAX_OUTST   = 4,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic                axilite_clk,
  input  logic                axilite_rstb,
  input  logic [1:0]          ch_start,
  input  logic [1:0]          ch_stop,
  input  logic [1:0]          ch_loop,
  input  logic [31:0]         ch0_base,
  input  logic [31:0]         ch1_base,
  input  logic [31:0]         ch0_size,
  input  logic [31:0]         ch1_size,
  mm2s_cmd_sched_if.master    dm,
  output logic [1:0]          ch_busy,
  output logic [1:0]          ch_err,
  output logic [15:0]         ch_passes,
  output logic [3:0]          outstanding,
  output logic                wdog_err
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]        req, gnt, pend, cmd_hs_ch, sts_hs_ch, sts_err_ch;
  mm2s_cmd_t [NUM_CH-1:0]   cmd_ch;
  logic [NUM_CH-1:0][31:0]  base_v, size_v;
  logic [NUM_CH-1:0][7:0]   passes_v;
  mm2s_cmd_t                cmd_q;
  logic                     cmd_vld, cmd_ch_q, last_ch, can_issue;
  logic                     cmd_hs, sts_hs, sts_bad, abort;
  logic [3:0]               sts_tag;

  assign base_v    = {ch1_base, ch0_base};
  assign size_v    = {ch1_size, ch0_size};
  assign ch_passes = passes_v;

  assign dm.m_axis_cmd_tvalid = cmd_vld;
  assign dm.m_axis_cmd_tdata  = cmd_q;
  assign dm.s_axis_sts_tready = 1'b1;

  assign cmd_hs  = cmd_vld && dm.m_axis_cmd_tready;
  // statuses with nothing in flight (e.g. left over from a reset) are dropped
  assign sts_hs  = dm.s_axis_sts_tvalid && (outstanding != '0);
  assign sts_tag = dm.s_axis_sts_tdata[TAG_W-1:0];
  assign sts_bad = sts_hs && sts_is_err(dm.s_axis_sts_tdata);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign pend[c]       = cmd_vld && (cmd_ch_q == 1'(c));
    assign cmd_hs_ch[c]  = cmd_hs && (cmd_ch_q == 1'(c));
    assign sts_hs_ch[c]  = sts_hs && (sts_tag[3] == 1'(c));
    assign sts_err_ch[c] = sts_bad && (sts_tag[3] == 1'(c));

    mm2s_chan_seq #(.PKT_BYTES(PKT_BYTES), .CH_ID(1'(c))) u_chan (
      .axilite_clk (axilite_clk),
      .axilite_rstb(axilite_rstb),
      .start       (ch_start[c]),
      .stop        (ch_stop[c]),
      .loop_in     (ch_loop[c]),
      .base_in     (base_v[c]),
      .size_in     (size_v[c]),
      .gnt         (gnt[c]),
      .pend        (pend[c]),
      .cmd_hs      (cmd_hs_ch[c]),
      .sts_hs      (sts_hs_ch[c]),
      .sts_err     (sts_err_ch[c]),
      .sts_seq     (sts_tag[2:0]),
      .abort       (abort),
      .req         (req[c]),
      .cmd         (cmd_ch[c]),
      .busy        (ch_busy[c]),
      .err         (ch_err[c]),
      .passes      (passes_v[c])
    );
  end

  assign can_issue = !cmd_vld && (outstanding < 4'(MAX_OUTST)) && !abort;

  // round-robin grant: the channel granted last loses a tie
  always_comb begin
    gnt = '0;
    if (can_issue) begin
      if (req == 2'b11) gnt = last_ch ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // command register: loaded on grant, held until the DataMover takes it
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb) begin
      cmd_vld <= 1'b0; cmd_q <= '0; cmd_ch_q <= 1'b0; last_ch <= 1'b1;
    end else if (abort) begin
      cmd_vld <= 1'b0;
    end else if (gnt != '0) begin
      cmd_vld  <= 1'b1;
      cmd_q    <= cmd_ch[gnt[1]];
      cmd_ch_q <= gnt[1];
      last_ch  <= gnt[1];
    end else if (cmd_hs) begin
      cmd_vld <= 1'b0;
    end

  // total commands in flight
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb)          outstanding <= '0;
    else if (abort)             outstanding <= '0;
    else if (cmd_hs && !sts_hs) outstanding <= outstanding + 4'd1;
    else if (!cmd_hs && sts_hs) outstanding <= outstanding - 4'd1;

`ifdef MM2S_SCHED_WDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_fire;
  assign wdog_fire = (outstanding != '0) && !sts_hs && (wdog_cnt == 32'(WDOG_CYCLES - 1));
  assign abort     = wdog_fire;

  // watchdog: cycles since last status while anything is in flight
  always_ff @(posedge axilite_clk or negedge axilite_rstb)
    if (!axilite_rstb) begin
      wdog_cnt <= '0; wdog_err <= 1'b0;
    end else begin
      if (outstanding == '0 || sts_hs || wdog_fire) wdog_cnt <= '0;
      else                                          wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_fire) wdog_err <= 1'b1;
    end
`else
  logic [31:0] wdog_unused;
  assign wdog_unused = 32'(WDOG_CYCLES);
  assign abort       = 1'b0;
  assign wdog_err    = 1'b0;
`endif
endmodule
